// File: rtl/text_area_pkg.sv
// Shared widths, control characters and FSM state type for the text area write path.
// TEXT_BACKSPACE_EN (see text_area_write_ctrl) relies on ASCII_BS defined here.
package text_area_pkg;

    localparam int TA_ADDR_W = 13;
    localparam int TA_DATA_W = 16;
    localparam int COL_W     = 7;
    localparam int LINE_W    = 6;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_BS = 8'h08;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ta_state_e;

endpackage

// File: rtl/text_cursor_counter.sv
// Column/line position register with advance, newline, carriage return, back and zero controls.
// Wraps at COLS-1 / ROWS-1; the *_next_o outputs expose the position being loaded this cycle.
module text_cursor_counter
    import text_area_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              zero_i,
    input  logic              newline_i,
    input  logic              cr_i,
    input  logic              back_i,
    input  logic              advance_i,
    output logic [COL_W-1:0]  col_o,
    output logic [LINE_W-1:0] line_o,
    output logic [COL_W-1:0]  col_next_o,
    output logic [LINE_W-1:0] line_next_o
);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(ROWS - 1);

    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] line_inc;

    assign line_inc = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;

    // Controls are mutually exclusive in practice; priority only matters for zero.
    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        if (zero_i) begin
            col_d  = '0;
            line_d = '0;
        end else if (newline_i) begin
            col_d  = '0;
            line_d = line_inc;
        end else if (cr_i) begin
            col_d = '0;
        end else if (back_i) begin
            if (col_q != '0) begin
                col_d = col_q - 1'b1;
            end else if (line_q != '0) begin
                col_d  = COL_LAST;
                line_d = line_q - 1'b1;
            end
        end else if (advance_i) begin
            if (col_q == COL_LAST) begin
                col_d  = '0;
                line_d = line_inc;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            line_q <= '0;
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
        end
    end

    assign col_o       = col_q;
    assign line_o      = line_q;
    assign col_next_o  = col_d;
    assign line_next_o = line_d;

endmodule

// File: rtl/text_area_write_ctrl.sv
// Port-B write controller for the text area: cursor-driven character writes and full-screen clear.
// Define TEXT_BACKSPACE_EN to make 0x08 a destructive backspace instead of a printable glyph.
//
// state | meaning
// IDLE  | accepts characters; a clear request moves to CLEAR next cycle
// CLEAR | writes one blank cell per cycle over every visible cell, then homes the cursor
module text_area_write_ctrl
    import text_area_pkg::*;
#(
    parameter int         COLS        = 80,
    parameter int         ROWS        = 60,
    parameter logic [7:0] BLANK_CHAR  = 8'h20,
    parameter logic [7:0] CLEAR_COLOR = 8'h07
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 char_valid,
    output logic                 char_ready,
    input  logic [7:0]           char_ascii,
    input  logic [7:0]           char_color,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 mem_we,
    output logic [TA_ADDR_W-1:0] mem_addr,
    output logic [TA_DATA_W-1:0] mem_din,
    output logic [COL_W-1:0]     cursor_col,
    output logic [LINE_W-1:0]    cursor_line
);

    ta_state_e             state_q;
    logic                  busy_q;
    logic                  ready_q;
    logic                  mem_we_q;
    logic [TA_ADDR_W-1:0]  mem_addr_q;
    logic [TA_DATA_W-1:0]  mem_din_q;

    logic                  is_cr, is_lf, is_bs, is_print;
    logic                  accept;
    logic                  scan_last;
    logic [COL_W-1:0]      cur_col_nxt, scan_col, scan_col_nxt;
    logic [LINE_W-1:0]     cur_line_nxt, scan_line, scan_line_nxt;
    logic [TA_ADDR_W-1:0]  wr_addr;

    assign is_cr = (char_ascii == ASCII_CR);
    assign is_lf = (char_ascii == ASCII_LF);
`ifdef TEXT_BACKSPACE_EN
    assign is_bs = (char_ascii == ASCII_BS);
`else
    assign is_bs = 1'b0;
`endif
    assign is_print = ~is_cr & ~is_lf & ~is_bs;

    // A same-cycle clear request must block the character, so it gates the registered ready.
    assign char_ready = ready_q & ~clear_req;
    assign accept     = char_valid & char_ready;

    // Backspace writes at the position the cursor is moving to; everything else at the current one.
    assign wr_addr = is_bs ? {cur_line_nxt, cur_col_nxt} : {cursor_line, cursor_col};

    // The scan only returns to (0,0) when stepping off the final visible cell.
    assign scan_last = (state_q == CLEAR) && (scan_col_nxt == '0) && (scan_line_nxt == '0);

    text_cursor_counter #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk         (clk),
        .rst_n       (rst_n),
        .zero_i      (scan_last),
        .newline_i   (accept & is_lf),
        .cr_i        (accept & is_cr),
        .back_i      (accept & is_bs),
        .advance_i   (accept & is_print),
        .col_o       (cursor_col),
        .line_o      (cursor_line),
        .col_next_o  (cur_col_nxt),
        .line_next_o (cur_line_nxt)
    );

    text_cursor_counter #(.COLS(COLS), .ROWS(ROWS)) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .zero_i      ((state_q == IDLE) & clear_req),
        .newline_i   (1'b0),
        .cr_i        (1'b0),
        .back_i      (1'b0),
        .advance_i   (state_q == CLEAR),
        .col_o       (scan_col),
        .line_o      (scan_line),
        .col_next_o  (scan_col_nxt),
        .line_next_o (scan_line_nxt)
    );

    // busy stays high through the registered final clear write, releasing one cycle after CLEAR ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (clear_req) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else if (accept && (is_print || is_bs)) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= wr_addr;
                        mem_din_q  <= {char_color, (is_bs ? BLANK_CHAR : char_ascii)};
                    end
                end
                CLEAR: begin
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= {scan_line, scan_col};
                    mem_din_q  <= {CLEAR_COLOR, BLANK_CHAR};
                    if (scan_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_text_area_write_ctrl.sv
// Randomized bench for text_area_write_ctrl against a cell-index reference model.
module tb_text_area_write_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;
`ifdef TEXT_BACKSPACE_EN
    localparam bit BS_EN = 1'b1;
`else
    localparam bit BS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [7:0]  char_ascii = 8'h00;
    logic [7:0]  char_color = 8'h00;
    logic        clear_req = 1'b0;
    logic        busy;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_din;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_line;

    always #5 clk = ~clk;

    text_area_write_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .char_ascii  (char_ascii),
        .char_color  (char_color),
        .clear_req   (clear_req),
        .busy        (busy),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .cursor_col  (cursor_col),
        .cursor_line (cursor_line)
    );

    int checks = 0;
    int failures = 0;

    // Model: cursor as (col,line); clear progress as clr_k (0 = none, 1..CELLS = next cell index + 1,
    // CELLS+1 = final write in flight).
    int   m_col, m_line, clr_k;
    bit   m_acc;
    logic        exp_we;
    logic [12:0] exp_addr;
    logic [15:0] exp_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [12:0] cell_addr(input int pos);
        return 13'((pos / COLS) * 128 + (pos % COLS));
    endfunction

    task automatic model_reset();
        m_col = 0;
        m_line = 0;
        clr_k = 0;
    endtask

    task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] c, input bit clr);
        int pos;
        @(negedge clk);
        char_valid = v;
        char_ascii = a;
        char_color = c;
        clear_req  = clr;
        #1;
        chk("char_ready", char_ready, (clr_k == 0 && !clr));
        exp_we = 1'b0;
        m_acc  = 1'b0;
        pos = m_line * COLS + m_col;
        if (clr_k == 0) begin
            if (clr) begin
                clr_k = 1;
            end else if (v) begin
                m_acc = 1'b1;
                if (a == 8'h0D) begin
                    m_col = 0;
                end else if (a == 8'h0A) begin
                    m_col = 0;
                    m_line = (m_line + 1) % ROWS;
                end else if (BS_EN && a == 8'h08) begin
                    if (pos > 0) pos--;
                    exp_we = 1'b1;
                    exp_addr = cell_addr(pos);
                    exp_din = {c, 8'h20};
                    m_col = pos % COLS;
                    m_line = pos / COLS;
                end else begin
                    exp_we = 1'b1;
                    exp_addr = cell_addr(pos);
                    exp_din = {c, a};
                    pos = (pos + 1) % CELLS;
                    m_col = pos % COLS;
                    m_line = pos / COLS;
                end
            end
        end else if (clr_k <= CELLS) begin
            exp_we = 1'b1;
            exp_addr = cell_addr(clr_k - 1);
            exp_din = 16'h0720;
            if (clr_k == CELLS) begin
                m_col = 0;
                m_line = 0;
            end
            clr_k++;
        end else begin
            clr_k = 0;
        end
        @(posedge clk);
        #1;
        chk("mem_we", mem_we, exp_we);
        if (exp_we) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_din", mem_din, exp_din);
        end
        chk("busy", busy, (clr_k != 0));
        chk("cursor_col", cursor_col, m_col);
        chk("cursor_line", cursor_line, m_line);
    endtask

    task automatic send_char(input logic [7:0] a, input logic [7:0] c);
        bit done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            cycle(1'b1, a, c, 1'b0);
            done = m_acc;
        end
        chk("send_accepted", done, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        char_valid = 1'b0;
        clear_req  = 1'b0;
        rst_n      = 1'b0;
        #1;
        model_reset();
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_col", cursor_col, m_col);
        chk("rst_line", cursor_line, m_line);
        chk("rst_addr", mem_addr, 13'h0000);
        chk("rst_din", mem_din, 16'h0000);
        chk("rst_ready", char_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_print();
        return 8'(8'h21 + $urandom_range(0, 93));
    endfunction

    initial begin
        apply_reset();

        // "AB" back-to-back
        send_char(8'h41, 8'h1F);
        send_char(8'h42, 8'h1F);

        // fill to column 79, then 'Z' at the row end and one more on the next line
        for (int i = 0; i < 77; i++) send_char(rand_print(), 8'($urandom_range(0, 255)));
        send_char(8'h5A, 8'h2E);
        send_char(8'h51, 8'h2E);

        // clear with a character held; a second pulse mid-clear is ignored
        cycle(1'b1, 8'h41, 8'h1E, 1'b1);
        for (int i = 0; i < 2000; i++) cycle(1'b1, 8'h41, 8'h1E, 1'b0);
        cycle(1'b1, 8'h41, 8'h1E, 1'b1);
        send_char(8'h41, 8'h1E);

        // CR / LF positioning around (5,3)
        send_char(8'h0D, 8'h00);
        for (int i = 0; i < 3; i++) send_char(8'h0A, 8'h00);
        for (int i = 0; i < 5; i++) send_char(rand_print(), 8'h11);
        send_char(8'h0D, 8'h00);
        for (int i = 0; i < 5; i++) send_char(rand_print(), 8'h12);
        send_char(8'h0A, 8'h00);

        // random mixed traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            int r = $urandom_range(0, 9);
            a = (r == 0) ? 8'h0D : (r == 1) ? 8'h0A : (r == 2) ? 8'h08 : rand_print();
            cycle(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)), 1'b0);
        end

        // last-line wrap: col wrap on line 59 returns to line 0, LF on line 59 too
        apply_reset();
        for (int i = 0; i < ROWS - 1; i++) send_char(8'h0A, 8'h00);
        for (int i = 0; i < COLS + 1; i++) send_char(rand_print(), 8'h33);
        for (int i = 0; i < ROWS; i++) send_char(8'h0A, 8'h00);
        send_char(8'h2A, 8'h44);

        // 0x08 at (0,0) and at (0,2)
        apply_reset();
        send_char(8'h08, 8'h5C);
        apply_reset();
        send_char(8'h0A, 8'h00);
        send_char(8'h0A, 8'h00);
        send_char(8'h08, 8'h6D);
        send_char(8'h08, 8'h6D);

        // reset mid-clear aborts; next char lands at 0x0000
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 101; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0);
        apply_reset();
        send_char(8'h55, 8'h0A);
        send_char(8'h56, 8'h0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/text_area_write_ctrl.md
Name: text_area_write_ctrl

Overview:
Write-side controller for the dual-port text area memory (8192 x 16; data = {color[7:0], ascii[7:0]}; address = {line[5:0], col[6:0]}). It owns memory port B, while port A stays the display read path. It arbitrates between a character stream (terminal-style cursor writes) and a clear-screen request. It keeps the cursor position and drives one registered write per cycle.

Parameters:
COLS, 80, visible columns; cursor col wraps at COLS-1 (COLS <= 128)
ROWS, 60, visible lines; cursor line wraps at ROWS-1 (ROWS <= 64)
BLANK_CHAR, 8'h20, ASCII written by clear
CLEAR_COLOR, 8'h07, color written by clear

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
char_valid  in  1  character request valid
char_ready  out  1  controller accepts character this cycle
char_ascii  in  8  character code
char_color  in  8  character color
clear_req  in  1  single-cycle pulse; request full-screen clear (latched)
busy  out  1  clear in progress or clear pending
mem_we  out  1  port B write enable
mem_addr  out  13  port B address {line, col}
mem_din  out  16  port B data {color, ascii}
cursor_col  out  7  current cursor column
cursor_line  out  6  current cursor line

Behaviour:
- Reset (async assert, sync deassert by the board reset sync):
  - state = IDLE; mem_we = 0; mem_addr = 0; mem_din = 0.
  - Cursor = (0,0); clear_pend = 0; busy = 0.
- All outputs are registered.
- States:
  - IDLE: char_ready = ~clear_pend & ~clear_req.
    - Accept = char_valid & char_ready.
    - On accept: process the character.
    - If clear_pend (or clear_req), go to CLEAR, loading clr_col = 0 and clr_line = 0.
  - CLEAR: char_ready = 0.
    - Each cycle: mem_we = 1, mem_addr = {clr_line, clr_col}, mem_din = {CLEAR_COLOR, BLANK_CHAR}.
    - clr_col increments; at COLS-1 it resets to 0 and clr_line increments.
    - After writing (COLS-1, ROWS-1): cursor = (0,0), clear_pend = 0, return to IDLE.
    - A clear takes exactly COLS*ROWS write cycles (4800 at defaults).
- Character processing on accept:
  - Printable (not 0x0A / 0x0D):
    - Next cycle: mem_we = 1, mem_addr = {cursor_line, cursor_col}, mem_din = {char_color, char_ascii}.
    - Cursor then advances: col+1; at COLS-1, col = 0 and line+1; at ROWS-1 the line wraps to 0 (no scroll).
  - 0x0D (CR): col = 0; no write.
  - 0x0A (LF): col = 0, line+1 with wrap; no write.
- Write latency: accept at cycle N gives mem_we high at N+1, for one cycle per char. Back-to-back accepts allowed; throughput is 1 char/cycle.
- mem_we is low on any cycle with no accepted printable char and no clear.
- Simultaneous clear_req and char_valid: clear wins; char_ready = 0 that cycle and the char stays pending at the source.
- clear_req during CLEAR: ignored; no restart and no queued second clear.
- Addresses never exceed {ROWS-1, COLS-1}. Columns COLS..127 and lines ROWS..63 are never written.
- Reset mid-clear: clear aborted, cursor = (0,0), memory contents undefined beyond what was written.
- busy = clear_pend | (state == CLEAR).

Optional Feature:
- Macro: TEXT_BACKSPACE_EN.
- Defined:
  - 0x08 moves the cursor back one cell: col-1; at col 0 go to (COLS-1, line-1); at (0,0) stay.
  - Then write {char_color, BLANK_CHAR} at the new position the next cycle.
- Undefined: 0x08 is treated as a printable character.

Decomposition:
- Package text_area_pkg holds:
  - TA_ADDR_W = 13, TA_DATA_W = 16, COL_W = 7, LINE_W = 6.
  - ASCII_CR, ASCII_LF, ASCII_BS.
  - State enum {IDLE, CLEAR}.
- Sub-module text_cursor_counter: col/line counter with advance, newline, back, and zero controls plus wrap at COLS/ROWS. It is instantiated twice: once for the cursor, once for the clear scan.

Test Plan:
- Reset, then send "AB" (0x41, 0x42, color 0x1F) back-to-back:
  - mem_we high for 2 cycles.
  - addr 0x0000 / data 0x1F41, then addr 0x0001 / data 0x1F42.
  - Cursor ends at (2,0).
- Send 79 chars, then "Z":
  - "Z" is written at addr {0, 7'd79} = 0x004F.
  - Cursor goes to (0,1).
  - The next char is written at 0x0080.
- Cursor at (5,3), send LF:
  - No write.
  - Cursor becomes (0,4).
  - CR at (5,3) gives (0,3).
- Pulse clear_req with char_valid held:
  - busy high and char_ready low for 4800 write cycles.
  - Last write is addr {6'd59, 7'd79} = 0x1DCF, data 0x0720.
  - Cursor returns to (0,0); then the pending char is accepted.
- Assert rst_n low mid-clear (e.g. after 100 writes):
  - mem_we drops immediately.
  - busy = 0, cursor = (0,0).
  - A new char after release is written at 0x0000.
- With TEXT_BACKSPACE_EN, cursor at (0,2), send 0x08:
  - Cursor becomes (79,1).
  - Write at 0x00CF with ascii 0x20.
